// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: locks to a VGA sync/RGB link and recovers x/y/de.
// Define VGA_SYNC_DECODER_ERRCNT_EN to add o_err_cnt (lock-loss count).
module vga_sync_decoder #(
  parameter int H_TOTAL   = 800,
  parameter int H_START   = 144,
  parameter int H_VISIBLE = 640,
  parameter int V_TOTAL   = 525,
  parameter int V_START   = 35,
  parameter int V_VISIBLE = 480,
  parameter bit SYNC_POL  = 1'b0,
  parameter int H_LOCK_N  = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic [2:0]  i_rgb,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_de,
  output logic [2:0]  o_rgb,
  output logic        o_frame_start,
  output logic [11:0] o_line_len,
  output logic [11:0] o_frame_lines,
  output logic        o_locked
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
  ,
  output logic [15:0] o_err_cnt
`endif
);

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } state_t;

  localparam logic       IDLE = !SYNC_POL;
  localparam logic [11:0] SAT = 12'hFFF;
  localparam logic [7:0] LOCK_N = 8'(H_LOCK_N);
  localparam logic [11:0] HT  = 12'(H_TOTAL);
  localparam logic [11:0] VT  = 12'(V_TOTAL);
  // Edge detect costs one stage more than the rgb path,
  // so pin column p meets hcnt == p-1 at the output reg.
  localparam logic [11:0] HX0 = 12'(H_START - 1);
  localparam logic [11:0] HX1 = 12'(H_START - 1 + H_VISIBLE);
  localparam logic [11:0] VY0 = 12'(V_START);
  localparam logic [11:0] VY1 = 12'(V_START + V_VISIBLE);

  state_t      state;
  logic [2:0]  hs_sr;
  logic [2:0]  vs_sr;
  logic [2:0]  rgb_s1;
  logic [2:0]  rgb_s2;
  logic [11:0] hcnt;
  logic [11:0] vcnt;
  logic [7:0]  good;
  logic [7:0]  good_nx;
  logic [11:0] len_nx;
  logic [11:0] frm_nx;
  logic        hs_edge;
  logic        vs_edge;
  logic        h_sat;
  logic        line_ok;
  logic        frame_ok;
  logic        lock_lost;
  logic        de_nx;

  assign hs_edge = (hs_sr[1] == SYNC_POL) && (hs_sr[2] != SYNC_POL);
  assign vs_edge = (vs_sr[1] == SYNC_POL) && (vs_sr[2] != SYNC_POL);
  assign h_sat    = (hcnt == SAT);
  assign len_nx   = h_sat ? SAT : hcnt + 12'd1;
  assign frm_nx   = (vcnt == SAT) ? SAT : vcnt + 12'd1;
  assign line_ok  = (len_nx == HT);
  assign frame_ok = (frm_nx == VT);
  assign o_locked = (state == LOCKED);

  assign lock_lost = (state == LOCKED) &&
                     ((hs_edge && !line_ok) ||
                      (vs_edge && !frame_ok) || h_sat);

  assign de_nx = (state == LOCKED) &&
                 (hcnt >= HX0) && (hcnt < HX1) &&
                 (vcnt >= VY0) && (vcnt < VY1);

  always_comb begin
    good_nx = good;
    if (hs_edge) begin
      if (!line_ok)
        good_nx = '0;
      else if (good < LOCK_N)
        good_nx = good + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= SEARCH;
      hs_sr         <= {3{IDLE}};
      vs_sr         <= {3{IDLE}};
      rgb_s1        <= '0;
      rgb_s2        <= '0;
      hcnt          <= '0;
      vcnt          <= '0;
      good          <= '0;
      o_line_len    <= '0;
      o_frame_lines <= '0;
      o_frame_start <= 1'b0;
      o_de          <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_rgb         <= '0;
    end else begin
      hs_sr  <= {hs_sr[1:0], i_hsync};
      vs_sr  <= {vs_sr[1:0], i_vsync};
      rgb_s1 <= i_rgb;
      rgb_s2 <= rgb_s1;

      if (hs_edge) begin
        hcnt       <= '0;
        o_line_len <= len_nx;
      end else if (!h_sat) begin
        hcnt <= hcnt + 12'd1;
      end

      if (vs_edge) begin
        vcnt          <= '0;
        o_frame_lines <= frm_nx;
      end else if (hs_edge && vcnt != SAT) begin
        vcnt <= vcnt + 12'd1;
      end

      o_frame_start <= vs_edge;

      unique case (state)
        SEARCH: begin
          if (hs_edge) begin
            state <= ACQUIRE;
            good  <= '0;
          end
        end
        ACQUIRE: begin
          good <= good_nx;
          if (vs_edge && frame_ok && good_nx >= LOCK_N)
            state <= LOCKED;
        end
        LOCKED: begin
          if (lock_lost)
            state <= SEARCH;
        end
        default: state <= SEARCH;
      endcase

      o_de  <= de_nx;
      o_x   <= de_nx ? hcnt - HX0 : '0;
      o_y   <= de_nx ? vcnt - VY0 : '0;
      o_rgb <= de_nx ? rgb_s2 : '0;
    end
  end

`ifdef VGA_SYNC_DECODER_ERRCNT_EN
  always_ff @(posedge i_clk) begin
    if (i_reset)
      o_err_cnt <= '0;
    else if (lock_lost && o_err_cnt != 16'hFFFF)
      o_err_cnt <= o_err_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: scoreboard bench on a shrunken video timing.
// Pixels are queued as driven and popped whenever o_de is seen.
module tb_vga_sync_decoder;

  localparam int HT  = 40;
  localparam int HS  = 8;
  localparam int HV  = 24;
  localparam int VT  = 20;
  localparam int VS  = 3;
  localparam int VV  = 14;
  localparam int HSW = 4;
  localparam int VSW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs  = 1'b1;
  logic        vs  = 1'b1;
  logic [2:0]  rgb = '0;
  logic [11:0] o_x;
  logic [11:0] o_y;
  logic        o_de;
  logic [2:0]  o_rgb;
  logic        o_frame_start;
  logic [11:0] o_line_len;
  logic [11:0] o_frame_lines;
  logic        o_locked;
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
  logic [15:0] o_err_cnt;
`endif

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [2:0]  rgb;
  } pix_t;

  pix_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   fs_seen = 0;
  bit   mon_en = 1'b0;

  vga_sync_decoder #(
    .H_TOTAL  (HT),
    .H_START  (HS),
    .H_VISIBLE(HV),
    .V_TOTAL  (VT),
    .V_START  (VS),
    .V_VISIBLE(VV),
    .SYNC_POL (1'b0),
    .H_LOCK_N (4)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_hsync      (hs),
    .i_vsync      (vs),
    .i_rgb        (rgb),
    .o_x          (o_x),
    .o_y          (o_y),
    .o_de         (o_de),
    .o_rgb        (o_rgb),
    .o_frame_start(o_frame_start),
    .o_line_len   (o_line_len),
    .o_frame_lines(o_frame_lines),
    .o_locked     (o_locked)
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    ,
    .o_err_cnt    (o_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] pat(input int p, input int l);
    int v;
    v = p - HS + 2 * (l - VS) + 4;
    return v[2:0];
  endfunction

  task automatic send_line(input int l, input int len, input bit exp,
                           input int probe_len, input bit probe_locked);
    for (int p = 0; p < len; p++) begin
      @(negedge clk);
      if (probe_len != 0 && p == 2 && probe_locked)
        check("lock_hold", 32'(o_locked), 1);
      if (probe_len != 0 && p == 3) begin
        check("lock_drop", 32'(o_locked), 0);
        check("line_len_probe", 32'(o_line_len), 32'(probe_len));
      end
      hs  = (p < HSW) ? 1'b0 : 1'b1;
      vs  = (l < VSW) ? 1'b0 : 1'b1;
      rgb = pat(p, l);
      if (exp && p >= HS && p < HS + HV && l >= VS && l < VS + VV)
        sbq.push_back(pix_t'{x: 12'(p - HS), y: 12'(l - VS),
                             rgb: pat(p, l)});
    end
  endtask

  task automatic send_frame(input bit exp, input int bad_line,
                            input int bad_len, input int first_probe);
    for (int l = 0; l < VT; l++) begin
      int  len;
      bit  e;
      int  pl;
      bit  pk;
      len = (l == bad_line) ? bad_len : HT;
      e   = exp && !(bad_line >= 0 && l > bad_line);
      pl  = 0;
      pk  = 1'b0;
      if (bad_line >= 0 && l == bad_line + 1) begin
        pl = bad_len;
        pk = 1'b1;
      end
      if (l == 0 && first_probe != 0)
        pl = first_probe;
      send_line(l, len, e, pl, pk);
    end
    check("sb_drain", 32'(sbq.size()), 0);
    sbq.delete();
  endtask

  initial begin
    pix_t e;
    wait (mon_en);
    forever begin
      @(posedge clk);
      #1;
      if (o_frame_start)
        fs_seen++;
      vectors++;
      if (o_de) begin
        if (sbq.size() == 0) begin
          miscompares++;
          $display("FAIL de_unexpected: got x=%0d y=%0d rgb=%0d required no de",
                   o_x, o_y, o_rgb);
        end else begin
          e = sbq.pop_front();
          if ({o_x, o_y, o_rgb} !== e) begin
            miscompares++;
            $display("FAIL pixel: got x=%0d y=%0d rgb=%0d required x=%0d y=%0d rgb=%0d",
                     o_x, o_y, o_rgb, e.x, e.y, e.rgb);
          end
        end
      end else if ({o_x, o_y, o_rgb} !== 27'd0) begin
        miscompares++;
        $display("FAIL idle_zero: got x=%0d y=%0d rgb=%0d required 0",
                 o_x, o_y, o_rgb);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_locked"}, 32'(o_locked), 0);
    check({tag, "_de"}, 32'(o_de), 0);
    check({tag, "_xyrgb"}, 32'({o_x, o_y, o_rgb}), 0);
    check({tag, "_fs"}, 32'(o_frame_start), 0);
    check({tag, "_line_len"}, 32'(o_line_len), 0);
    check({tag, "_frame_lines"}, 32'(o_frame_lines), 0);
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    check({tag, "_err_cnt"}, 32'(o_err_cnt), 0);
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (4) @(negedge clk);
    check("no_spurious_fs", 32'(fs_seen), 0);
    check("no_spurious_len", 32'(o_line_len), 0);

    send_frame(1'b0, -1, 0, 0);
    check("A_locked", 32'(o_locked), 0);
    check("A_frame_lines", 32'(o_frame_lines), 1);
    check("A_line_len", 32'(o_line_len), 40);
    check("A_fs", 32'(fs_seen), 1);

    send_frame(1'b1, -1, 0, 0);
    check("B_locked", 32'(o_locked), 1);
    check("B_frame_lines", 32'(o_frame_lines), 20);
    send_frame(1'b1, -1, 0, 0);
    check("C_line_len", 32'(o_line_len), 40);

    send_frame(1'b1, 8, 39, 0);
    check("D_locked", 32'(o_locked), 0);
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    check("D_err_cnt", 32'(o_err_cnt), 1);
`endif
    send_frame(1'b1, -1, 0, 0);
    check("E_relocked", 32'(o_locked), 1);

    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      hs = 1'b1;
      vs = 1'b1;
      if (k == 4000)
        check("hold_pre_sat", 32'(o_locked), 1);
      if (k == 4200) begin
        check("hold_sat_unlock", 32'(o_locked), 0);
        check("hold_no_de", 32'(o_de), 0);
      end
    end

    send_frame(1'b0, -1, 0, 4095);
    send_frame(1'b1, -1, 0, 0);
    check("G_locked", 32'(o_locked), 1);
    check("G_line_len", 32'(o_line_len), 40);

    for (int l = 0; l < 10; l++)
      send_line(l, HT, 1'b1, 0, 1'b0);
    send_line(10, 36, 1'b1, 0, 1'b0);
    @(negedge clk);
    check("H_locked_mid", 32'(o_locked), 1);
    check("H_drain", 32'(sbq.size()), 0);
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    check("H_err_cnt", 32'(o_err_cnt), 2);
`endif
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("midrst");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_fs", 32'(fs_seen), 8);
    check("post_rst_len", 32'(o_line_len), 0);
    check("post_rst_lines", 32'(o_frame_lines), 0);

    send_frame(1'b0, -1, 0, 0);
    check("I_frame_lines", 32'(o_frame_lines), 1);
    send_frame(1'b1, -1, 0, 0);
    check("J_locked", 32'(o_locked), 1);
    repeat (5) @(negedge clk);
    check("fs_total", 32'(fs_seen), 10);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
